// File: rtl/fx2_pkg.sv
// Shared constants and helpers for the FX2 slave-FIFO packet model.
// Flags on the FX2 pins are active-low; the statistics counters saturate instead of wrapping.
package fx2_pkg;

    localparam int   STAT_W   = 16;
    localparam logic FLAG_ON  = 1'b0;
    localparam logic FLAG_OFF = 1'b1;

    // EP2 -> 0, EP4 -> 1, EP6 -> 2, EP8 -> 3
    function automatic logic [1:0] fifo_addr(input int ep);
        return 2'(ep / 2 - 1);
    endfunction

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/fx2_ep_fifo.sv
// Endpoint FIFO with first-word fall-through read.
// COMMIT_MODE=1 keeps written words invisible to the reader until commit is pulsed.
module fx2_ep_fifo #(
    parameter int NB          = 16,
    parameter int M           = 9,
    parameter int COMMIT_MODE = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [NB-1:0] wr_data,
    input  logic          commit,
    input  logic          rd_en,
    output logic [NB-1:0] rd_data,
    output logic [M:0]    count,
    output logic [M:0]    occupancy
);

    localparam int DEPTH = 1 << M;

    logic [NB-1:0] mem [DEPTH];
    logic [M:0]    wr_ptr;
    logic [M:0]    cmt_ptr;
    logic [M:0]    rd_ptr;
    logic [M:0]    wr_ptr_nx;
    logic          do_commit;

    assign wr_ptr_nx = wr_ptr + (M+1)'(wr_en);
    // Commit pointer includes a word written in the same cycle as the commit.
    assign do_commit = (COMMIT_MODE == 0) || commit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            cmt_ptr <= '0;
            rd_ptr  <= '0;
        end else begin
            wr_ptr <= wr_ptr_nx;
            if (do_commit)
                cmt_ptr <= wr_ptr_nx;
            if (rd_en)
                rd_ptr <= rd_ptr + (M+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr[M-1:0]] <= wr_data;
    end

    assign rd_data   = mem[rd_ptr[M-1:0]];
    assign count     = cmt_ptr - rd_ptr;
    assign occupancy = wr_ptr - rd_ptr;

endmodule

// File: rtl/fx2_packet_model.sv
// FX2 slave-FIFO model with USB packet commit semantics: INEP (host -> FPGA) and
// OUTEP (FPGA -> host, visible to the host only after a packet commits).
module fx2_packet_model
    import fx2_pkg::*;
#(
    parameter int NB        = 16,
    parameter int M         = 9,
    parameter int PKT_WORDS = 256,
    parameter int PF_MARGIN = 4,
    parameter int OUTEP     = 2,
    parameter int INEP      = 6
) (
    input  logic              clk,
    input  logic              reset,
    inout  wire  [NB-1:0]     fd,
    input  logic              SLWR,
    input  logic              SLRD,
    input  logic              SLOE,
    input  logic              PKTEND,
    input  logic [1:0]        FIFOADDR,
    output logic              EMPTY_FLAG,
    output logic              FULL_FLAG,
    output logic              PF_FLAG,
    input  logic [NB-1:0]     in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [NB-1:0]     out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [STAT_W-1:0] overflow_count,
    output logic [STAT_W-1:0] underflow_count,
    output logic [STAT_W-1:0] misdir_count,
    output logic [STAT_W-1:0] zlp_count
);

    localparam logic [1:0] IN_ADDR  = fifo_addr(INEP);
    localparam logic [1:0] OUT_ADDR = fifo_addr(OUTEP);
    localparam logic [M:0] DEPTH_W  = (M+1)'(1 << M);
    localparam logic [M:0] PKT_LIM  = (M+1)'(PKT_WORDS);
    localparam logic [M:0] PF_LIM   = (M+1)'((1 << M) - PF_MARGIN);

    logic [NB-1:0] in_head;
    logic [M:0]    in_count, in_occ, in_count_nx;
    logic [M:0]    out_count, out_occ, out_occ_nx;
    logic [M:0]    uncmt, uncmt_after;
    logic          in_sel, out_sel;
    logic          rd_req, in_empty, in_push, in_pop;
    logic          wr_req, out_full, out_wr, out_pop;
    logic          pkt_req, out_commit;
    logic          overflow_ev, underflow_ev, misdir_ev, zlp_ev;

    assign in_sel   = (FIFOADDR == IN_ADDR);
    assign out_sel  = (FIFOADDR == OUT_ADDR);

    assign in_empty = (in_count == '0);
    assign in_ready = !reset && (in_occ != DEPTH_W);
    assign in_push  = in_valid && in_ready;
    assign rd_req   = !SLRD && in_sel;
    assign in_pop   = rd_req && !in_empty;

    assign out_full = (out_occ == DEPTH_W);
    assign wr_req   = !SLWR && out_sel;
    assign out_wr   = wr_req && !out_full;
    assign out_valid = (out_count != '0);
    assign out_pop  = out_valid && out_ready;

    // A same-cycle write joins the packet before PKTEND decides whether it is empty.
    assign uncmt       = out_occ - out_count;
    assign uncmt_after = uncmt + (M+1)'(out_wr);
    assign pkt_req     = !PKTEND && out_sel;
    assign out_commit  = (out_wr && (uncmt_after == PKT_LIM)) ||
                         (pkt_req && (uncmt_after != '0));

    assign overflow_ev  = wr_req && out_full;
    assign underflow_ev = rd_req && in_empty;
    assign zlp_ev       = pkt_req && (uncmt_after == '0);
    assign misdir_ev    = (!SLRD && !in_sel) || ((!SLWR || !PKTEND) && !out_sel);

    assign in_count_nx = in_count + (M+1)'(in_push) - (M+1)'(in_pop);
    assign out_occ_nx  = out_occ + (M+1)'(out_wr) - (M+1)'(out_pop);

    assign fd = (!SLOE && in_sel) ? (in_empty ? '0 : in_head) : 'z;

    fx2_ep_fifo #(.NB(NB), .M(M), .COMMIT_MODE(0)) u_in_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (in_push),
        .wr_data   (in_data),
        .commit    (1'b0),
        .rd_en     (in_pop),
        .rd_data   (in_head),
        .count     (in_count),
        .occupancy (in_occ)
    );

    fx2_ep_fifo #(.NB(NB), .M(M), .COMMIT_MODE(1)) u_out_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (out_wr),
        .wr_data   (fd),
        .commit    (out_commit),
        .rd_en     (out_pop),
        .rd_data   (out_data),
        .count     (out_count),
        .occupancy (out_occ)
    );

    // Flags load the post-edge counts so they track the FIFO state without extra lag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            EMPTY_FLAG      <= FLAG_ON;
            FULL_FLAG       <= FLAG_OFF;
            PF_FLAG         <= FLAG_OFF;
            overflow_count  <= '0;
            underflow_count <= '0;
            misdir_count    <= '0;
            zlp_count       <= '0;
        end else begin
            EMPTY_FLAG <= (in_count_nx == '0) ? FLAG_ON : FLAG_OFF;
            FULL_FLAG  <= (out_occ_nx == DEPTH_W) ? FLAG_ON : FLAG_OFF;
            PF_FLAG    <= (out_occ_nx < PF_LIM) ? FLAG_OFF : FLAG_ON;
            if (overflow_ev)
                overflow_count <= sat_inc(overflow_count);
            if (underflow_ev)
                underflow_count <= sat_inc(underflow_count);
            if (misdir_ev)
                misdir_count <= sat_inc(misdir_count);
            if (zlp_ev)
                zlp_count <= sat_inc(zlp_count);
        end
    end

endmodule
